iqueue_decoder: RTL and testbench

//  Front-end dispatch stage of the LC-3b Tomasulo core. Buffers fetched {pc, instruction, prediction}
//  in an in-order FIFO, decodes the head entry, renames operands against the register status file,
//  and issues it to a free reservation station plus the reorder buffer, stalling when none is free.

---
 rtl/iqueue_decoder.sv | 242 ++++++++++++++++++++++++
 tb/tb_iqueue_decoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/iqueue_decoder.sv
// iqueue_decoder: in-order instruction queue plus decode/rename/issue stage.
// The head entry is decoded combinationally. Operands are renamed against the
// register status file. The head issues to a free reservation station and to
// the ROB. TRAP and RTI are dropped, which pops them without issuing.
module iqueue_decoder #(
    parameter int DEPTH = 8,
    parameter int ROB_W = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    input_ready,
    input  logic [15:0]             pc,
    input  logic [15:0]             instruction,
    input  logic                    branch_prediction,
    input  logic                    stall_output,
    input  logic [8*(17+ROB_W)-1:0] regfile_data,
    input  logic [4:0]              reservations_available,
    output logic                    stall_input,
    output logic [4:0]              ld_reservations,
    output logic                    load_reorder,
    output logic [2:0]              res_id_out,
    output logic [3:0]              op_out,
    output logic [ROB_W-1:0]        qj_out,
    output logic [ROB_W-1:0]        qk_out,
    output logic [15:0]             vj_out,
    output logic [15:0]             vk_out,
    output logic [3:0]              dest_reg_out,
    output logic [ROB_W+16:0]       store_val,
    output logic [15:0]             pc_out,
    output logic                    prediction_out,
    output logic                    lq,
    output logic                    sq
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = 17 + ROB_W;

    localparam logic [2:0] RS_NONE = 3'd0;
    localparam logic [2:0] RS_ALU  = 3'd1;
    localparam logic [2:0] RS_LD   = 3'd2;
    localparam logic [2:0] RS_ST   = 3'd3;
    localparam logic [2:0] RS_BR   = 3'd4;

    logic [15:0]    pc_mem [DEPTH];
    logic [15:0]    ir_mem [DEPTH];
    logic           pred_mem [DEPTH];
    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count;
    logic [3:0]     last_cc_reg;

    logic           valid, full, push, pop, issue, drop, gen_cc;
    logic [15:0]    ir, hpc;

    logic              rf_busy [8];
    logic [ROB_W-1:0]  rf_tag  [8];
    logic [15:0]       rf_val  [8];

    // Unpack the register status file into per-register fields.
    always_comb begin
        for (int r = 0; r < 8; r++) begin
            rf_busy[r] = regfile_data[r*EW + EW - 1];
            rf_tag[r]  = regfile_data[r*EW + 16 +: ROB_W];
            rf_val[r]  = regfile_data[r*EW +: 16];
        end
    end

    assign valid       = (count != '0);
    assign full        = (count == CW'(DEPTH));
    assign stall_input = full;
    assign ir          = ir_mem[rd_ptr];
    assign hpc         = pc_mem[rd_ptr];
    // Flush takes priority over push, so a fetch arriving with a flush is lost.
    assign push        = input_ready && !full && !flush;

    // Field extraction and renamed source operands for the head entry.
    logic [2:0]       f_dr, f_sr1, f_sr2;
    logic [15:0]      imm5, off6, off9, off11, pc2;
    logic [ROB_W-1:0] j_q, k_q;
    logic [15:0]      j_v, k_v;

    assign f_dr  = ir[11:9];
    assign f_sr1 = ir[8:6];
    assign f_sr2 = ir[2:0];
    assign imm5  = {{11{ir[4]}}, ir[4:0]};
    assign off6  = {{10{ir[5]}}, ir[5:0]};
    assign off9  = {{7{ir[8]}}, ir[8:0]};
    assign off11 = {{5{ir[10]}}, ir[10:0]};
    assign pc2   = hpc + 16'd2;
    assign j_q   = rf_busy[f_sr1] ? rf_tag[f_sr1] : '0;
    assign j_v   = rf_busy[f_sr1] ? 16'h0 : rf_val[f_sr1];
    assign k_q   = rf_busy[f_sr2] ? rf_tag[f_sr2] : '0;
    assign k_v   = rf_busy[f_sr2] ? 16'h0 : rf_val[f_sr2];

    // Decode the head entry. An empty queue presents an idle, zeroed bundle.
    always_comb begin
        res_id_out     = RS_NONE;
        op_out         = 4'h0;
        qj_out         = '0;
        qk_out         = '0;
        vj_out         = 16'h0;
        vk_out         = 16'h0;
        dest_reg_out   = 4'd8;
        store_val      = '0;
        lq             = 1'b0;
        sq             = 1'b0;
        gen_cc         = 1'b0;
        pc_out         = 16'h0;
        prediction_out = 1'b0;
        if (valid) begin
            op_out         = ir[15:12];
            pc_out         = hpc;
            prediction_out = pred_mem[rd_ptr];
            case (ir[15:12])
                4'b0001, 4'b0101: begin            // ADD / AND
                    res_id_out   = RS_ALU;
                    qj_out       = j_q;
                    vj_out       = j_v;
                    if (ir[5]) begin
                        vk_out = imm5;
                    end else begin
                        qk_out = k_q;
                        vk_out = k_v;
                    end
                    dest_reg_out = {1'b0, f_dr};
                    gen_cc       = 1'b1;
                end
                4'b1001: begin                     // NOT
                    res_id_out   = RS_ALU;
                    qj_out       = j_q;
                    vj_out       = j_v;
                    vk_out       = 16'hFFFF;
                    dest_reg_out = {1'b0, f_dr};
                    gen_cc       = 1'b1;
                end
                4'b1101: begin                     // SHF
                    res_id_out   = RS_ALU;
                    qj_out       = j_q;
                    vj_out       = j_v;
                    vk_out       = {10'h0, ir[5:0]};
                    dest_reg_out = {1'b0, f_dr};
                    gen_cc       = 1'b1;
                end
                4'b1110: begin                     // LEA
                    res_id_out   = RS_ALU;
                    vj_out       = pc2 + (off9 << 1);
                    dest_reg_out = {1'b0, f_dr};
                end
                4'b0110, 4'b1010, 4'b0010: begin   // LDR / LDI / LDB
                    res_id_out   = RS_LD;
                    qj_out       = j_q;
                    vj_out       = j_v;
                    vk_out       = (ir[15:12] == 4'b0010) ? off6 : (off6 << 1);
                    dest_reg_out = {1'b0, f_dr};
                    gen_cc       = 1'b1;
                    lq           = 1'b1;
                end
                4'b0111, 4'b1011, 4'b0011: begin   // STR / STI / STB
                    res_id_out   = RS_ST;
                    qj_out       = j_q;
                    vj_out       = j_v;
                    vk_out       = (ir[15:12] == 4'b0011) ? off6 : (off6 << 1);
                    store_val    = regfile_data[f_dr*EW +: EW];
                    sq           = 1'b1;
                end
                4'b0000: begin                     // BR: waits on the last cc producer
                    res_id_out = RS_BR;
                    vj_out     = pc2 + (off9 << 1);
                    vk_out     = {13'h0, ir[11:9]};
                    if (!last_cc_reg[3] && rf_busy[last_cc_reg[2:0]])
                        qj_out = rf_tag[last_cc_reg[2:0]];
                end
                4'b1100: begin                     // JMP / RET
                    res_id_out = RS_BR;
                    qj_out     = j_q;
                    vj_out     = j_v;
                end
                4'b0100: begin                     // JSR / JSRR
                    res_id_out   = RS_BR;
                    dest_reg_out = 4'd7;
                    if (ir[11]) begin
                        vj_out = pc2 + (off11 << 1);
                    end else begin
                        qj_out = j_q;
                        vj_out = j_v;
                    end
                end
                default: ;                         // TRAP / RTI: dropped
            endcase
        end
    end

    assign issue = valid && (res_id_out != RS_NONE) && reservations_available[res_id_out]
                   && !stall_output && !flush;
    assign drop  = valid && (res_id_out == RS_NONE) && !stall_output && !flush;
    assign pop   = issue || drop;
    assign load_reorder = issue;

    // One-hot load strobe to the selected station.
    always_comb begin
        ld_reservations = 5'b0;
        ld_reservations[res_id_out] = issue;
    end

    // Queue storage. It needs no reset because the valid count guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= pc;
            ir_mem[wr_ptr]   <= instruction;
            pred_mem[wr_ptr] <= branch_prediction;
        end
    end

    // Queue pointers and occupancy. DEPTH is a power of 2, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Track the most recently issued condition-code producer for branch renaming.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_cc_reg <= 4'd8;
        else if (issue && gen_cc)
            last_cc_reg <= dest_reg_out;
    end
endmodule

// File: tb/tb_iqueue_decoder.sv
// Scoreboard bench for iqueue_decoder. Each directed stimulus pushes its
// hand-computed issue bundle into a queue. A negedge monitor compares every
// issue the DUT makes against the queue head.
module tb_iqueue_decoder;
    localparam int ROB_W = 3;

    logic                clk = 1'b0;
    logic                reset, flush, input_ready, branch_prediction, stall_output;
    logic [15:0]         pc, instruction;
    logic [8*20-1:0]     regfile_data;
    logic [4:0]          reservations_available;
    logic                stall_input, load_reorder, prediction_out, lq, sq;
    logic [4:0]          ld_reservations;
    logic [2:0]          res_id_out;
    logic [3:0]          op_out, dest_reg_out;
    logic [2:0]          qj_out, qk_out;
    logic [15:0]         vj_out, vk_out, pc_out;
    logic [19:0]         store_val;

    logic                rf_busy [8];
    logic [2:0]          rf_tag  [8];
    logic [15:0]         rf_val  [8];

    typedef struct packed {
        logic [4:0]  ld;
        logic [2:0]  res;
        logic [3:0]  op;
        logic [2:0]  qj;
        logic [2:0]  qk;
        logic [15:0] vj;
        logic [15:0] vk;
        logic [3:0]  dest;
        logic [19:0] sv;
        logic        lq;
        logic        sq;
        logic [15:0] pc;
    } issue_t;

    issue_t sb [$];
    int total = 0;
    int bad   = 0;

    iqueue_decoder #(.DEPTH(8), .ROB_W(ROB_W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .input_ready(input_ready),
        .pc(pc), .instruction(instruction), .branch_prediction(branch_prediction),
        .stall_output(stall_output), .regfile_data(regfile_data),
        .reservations_available(reservations_available), .stall_input(stall_input),
        .ld_reservations(ld_reservations), .load_reorder(load_reorder),
        .res_id_out(res_id_out), .op_out(op_out), .qj_out(qj_out), .qk_out(qk_out),
        .vj_out(vj_out), .vk_out(vk_out), .dest_reg_out(dest_reg_out),
        .store_val(store_val), .pc_out(pc_out), .prediction_out(prediction_out),
        .lq(lq), .sq(sq)
    );

    always #5 clk = ~clk;

    always_comb begin
        regfile_data = '0;
        for (int r = 0; r < 8; r++)
            regfile_data[r*20 +: 20] = {rf_busy[r], rf_tag[r], rf_val[r]};
    end

    // Monitor: every issue must match the oldest outstanding expectation.
    always @(negedge clk) begin
        issue_t act, e;
        if (!reset && load_reorder) begin
            act = '{ld: ld_reservations, res: res_id_out, op: op_out, qj: qj_out, qk: qk_out,
                    vj: vj_out, vk: vk_out, dest: dest_reg_out, sv: store_val,
                    lq: lq, sq: sq, pc: pc_out};
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_issue got=%h want=none", act);
            end else begin
                e = sb.pop_front();
                if (act !== e) begin
                    bad++;
                    $display("FAIL issue got=%h want=%h", act, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic expect_issue(input logic [2:0] res, input logic [3:0] op,
                                input logic [2:0] qj, input logic [2:0] qk,
                                input logic [15:0] vj, input logic [15:0] vk,
                                input logic [3:0] dest, input logic [19:0] sv,
                                input logic l, input logic s, input logic [15:0] p);
        issue_t e;
        e = '{ld: 5'b1 << res, res: res, op: op, qj: qj, qk: qk, vj: vj, vk: vk,
              dest: dest, sv: sv, lq: l, sq: s, pc: p};
        sb.push_back(e);
    endtask

    // Present one instruction for a single cycle. Entry and exit are 1ns after posedge.
    task automatic push_instr(input logic [15:0] p, input logic [15:0] i);
        input_ready = 1'b1;
        pc          = p;
        instruction = i;
        @(posedge clk); #1;
        input_ready = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; input_ready = 1'b0; branch_prediction = 1'b0;
        stall_output = 1'b0; pc = 16'h0; instruction = 16'h0;
        reservations_available = 5'b11110;
        for (int r = 0; r < 8; r++) begin
            rf_busy[r] = 1'b0; rf_tag[r] = 3'd0; rf_val[r] = 16'h0;
        end
        rf_val[2] = 16'd5;
        rf_val[3] = 16'd7;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle outputs after reset.
        check("rst_stall_input", 32'(stall_input), 32'd0);
        check("rst_ld_res", 32'(ld_reservations), 32'd0);
        check("rst_load_reorder", 32'(load_reorder), 32'd0);
        check("rst_res_id", 32'(res_id_out), 32'd0);

        // ADD R1,R2,#3 with R2 ready = 5.
        expect_issue(3'd1, 4'h1, 3'd0, 3'd0, 16'd5, 16'd3, 4'd1, 20'h0, 1'b0, 1'b0, 16'h3000);
        push_instr(16'h3000, 16'h12A3);
        wait_cycles(3);

        // ADD R1,R2,R3 with R2 busy tag 4 and R3 ready = 7.
        rf_busy[2] = 1'b1; rf_tag[2] = 3'd4;
        expect_issue(3'd1, 4'h1, 3'd4, 3'd0, 16'd0, 16'd7, 4'd1, 20'h0, 1'b0, 1'b0, 16'h3002);
        push_instr(16'h3002, 16'h1283);
        wait_cycles(3);
        rf_busy[2] = 1'b0; rf_tag[2] = 3'd0;

        // Fill the queue with ALU ops while station 1 is busy.
        reservations_available = 5'b11100;
        for (int i = 0; i < 8; i++) begin
            expect_issue(3'd1, 4'h1, 3'd0, 3'd0, 16'd5, 16'(i), 4'd1, 20'h0, 1'b0, 1'b0,
                         16'h3010 + 16'(2*i));
            push_instr(16'h3010 + 16'(2*i), 16'h12A0 | 16'(i));
        end
        check("full_stall_input", 32'(stall_input), 32'd1);
        check("full_no_issue", 32'(load_reorder), 32'd0);
        push_instr(16'h30F0, 16'h12A9);           // must be ignored
        check("full_after_extra", 32'(stall_input), 32'd1);
        reservations_available = 5'b11110;
        wait_cycles(12);
        check("drained_stall_input", 32'(stall_input), 32'd0);

        // LDR R4,R2,#1 then BR n #2. R4 is busy with tag 6 in the status file.
        rf_busy[4] = 1'b1; rf_tag[4] = 3'd6;
        expect_issue(3'd2, 4'h6, 3'd0, 3'd0, 16'd5, 16'd2, 4'd4, 20'h0, 1'b1, 1'b0, 16'h2FFE);
        expect_issue(3'd4, 4'h0, 3'd6, 3'd0, 16'h3006, 16'd4, 4'd8, 20'h0, 1'b0, 1'b0, 16'h3000);
        push_instr(16'h2FFE, 16'h6881);
        push_instr(16'h3000, 16'h0802);
        wait_cycles(4);

        // Backend stall holds issuable entries. A flush then empties the queue and
        // suppresses issue, and a push in the same cycle is lost.
        stall_output = 1'b1;
        push_instr(16'h3200, 16'h12A1);
        push_instr(16'h3202, 16'h12A2);
        push_instr(16'h3204, 16'h12A3);
        check("stall_output_blocks", 32'(load_reorder), 32'd0);
        flush = 1'b1; stall_output = 1'b0;
        input_ready = 1'b1; pc = 16'h3206; instruction = 16'h12A4;
        @(negedge clk);
        check("flush_no_issue", 32'(load_reorder), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; input_ready = 1'b0;
        check("flush_empty_res", 32'(res_id_out), 32'd0);
        check("flush_empty_stall", 32'(stall_input), 32'd0);
        wait_cycles(4);

        // STB R5,R6,#-1. store_val is the raw status entry of R5.
        rf_busy[5] = 1'b1; rf_tag[5] = 3'd3; rf_val[5] = 16'h1234;
        rf_val[6]  = 16'h4000;
        expect_issue(3'd3, 4'h3, 3'd0, 3'd0, 16'h4000, 16'hFFFF, 4'd8,
                     {1'b1, 3'd3, 16'h1234}, 1'b0, 1'b1, 16'h3300);
        push_instr(16'h3300, 16'h3BBF);
        wait_cycles(3);

        // TRAP is dropped without issuing, and the ADD behind it still issues.
        expect_issue(3'd1, 4'h1, 3'd0, 3'd0, 16'd5, 16'd1, 4'd3, 20'h0, 1'b0, 1'b0, 16'h3102);
        push_instr(16'h3100, 16'hF025);
        push_instr(16'h3102, 16'h16A1);
        wait_cycles(5);
        check("queue_empty_res", 32'(res_id_out), 32'd0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
